// File: rtl/fan_ramp_ctrl.sv
// rtl/fan_ramp_ctrl.sv - fan speed sequencer: spin-up kick, rate-limited ramp, PWM
// Applied speed never moves more than one code per RAMP_DIV cycles, except for the kick.
module fan_ramp_ctrl #(
  parameter int RAMP_DIV    = 4,
  parameter int KICK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic [3:0] target,
  output logic [3:0] speed_o,
  output logic       pwm_o,
  output logic       busy_o,
  output logic       at_target_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KICK,
    ST_RAMP,
    ST_HOLD
  } state_t;

  localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);
  localparam logic [7:0] KICK_LOAD = 8'(KICK_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] speed_q, speed_d;
  logic [7:0] kick_cnt_q, kick_cnt_d;
  logic [7:0] ramp_cnt_q, ramp_cnt_d;
  logic [3:0] pwm_cnt_q;
  logic [3:0] eff;

  assign eff = enable ? target : 4'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      speed_q    <= 4'd0;
      kick_cnt_q <= 8'd0;
      ramp_cnt_q <= 8'd0;
      pwm_cnt_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      kick_cnt_q <= kick_cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
      pwm_cnt_q  <= pwm_cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    kick_cnt_d = kick_cnt_q;
    ramp_cnt_d = ramp_cnt_q;
    case (state_q)
      ST_IDLE: begin
        speed_d = 4'd0;
        if (eff != 4'd0) begin
          state_d    = ST_KICK;
          speed_d    = 4'd15;
          kick_cnt_d = KICK_LOAD;
        end
      end
      ST_KICK: begin
        // Dropping the request aborts the kick into a normal ramp-down.
        if (eff == 4'd0 || kick_cnt_q == 8'd0) begin
          state_d    = ST_RAMP;
          ramp_cnt_d = 8'd0;
        end else begin
          kick_cnt_d = kick_cnt_q - 8'd1;
        end
      end
      ST_RAMP: begin
        if (speed_q == eff) begin
          state_d = (eff == 4'd0) ? ST_IDLE : ST_HOLD;
        end else if (ramp_cnt_q == RAMP_LAST) begin
          // Direction follows the current eff; a one-code step cannot overshoot or wrap.
          speed_d    = (eff > speed_q) ? speed_q + 4'd1 : speed_q - 4'd1;
          ramp_cnt_d = 8'd0;
        end else begin
          ramp_cnt_d = ramp_cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (eff != speed_q) begin
          state_d    = ST_RAMP;
          ramp_cnt_d = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign speed_o     = speed_q;
  assign pwm_o       = (pwm_cnt_q < speed_q);
  assign busy_o      = (state_q == ST_KICK) || (state_q == ST_RAMP);
  assign at_target_o = (state_q == ST_HOLD) || ((state_q == ST_IDLE) && (eff == 4'd0));

endmodule

// File: tb/tb_fan_ramp_ctrl.sv
// tb/tb_fan_ramp_ctrl.sv - scoreboard bench for fan_ramp_ctrl with default parameters
// Expected per-edge speed/busy/at_target come from the timeline rules; PWM from edge count.
module tb_fan_ramp_ctrl;

  logic       clk;
  logic       rstn;
  logic       enable;
  logic [3:0] target;
  logic [3:0] speed_o;
  logic       pwm_o;
  logic       busy_o;
  logic       at_target_o;

  typedef struct packed {
    logic [3:0] speed;
    logic       busy;
    logic       at;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   ecnt;

  fan_ramp_ctrl #(.RAMP_DIV(4), .KICK_CYCLES(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .target     (target),
    .speed_o    (speed_o),
    .pwm_o      (pwm_o),
    .busy_o     (busy_o),
    .at_target_o(at_target_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  function automatic logic [3:0] ramp_speed(input int r, input int s0, input int t);
    int j;
    int n;
    j = r / 4;
    n = (t > s0) ? t - s0 : s0 - t;
    if (j >= n) return 4'(t);
    return (t > s0) ? 4'(s0 + j) : 4'(s0 - j);
  endfunction

  task automatic push_exp(input logic [3:0] s, input logic b, input logic a);
    exp_t e;
    e.speed = s;
    e.busy  = b;
    e.at    = a;
    exp_q.push_back(e);
  endtask

  // r counts edges since the edge that entered RAMP (r = 0 is that edge).
  task automatic push_ramp(input int s0, input int t, input int r_from, input int r_to);
    int n;
    n = (t > s0) ? t - s0 : s0 - t;
    for (int r = r_from; r <= r_to; r++)
      push_exp(ramp_speed(r, s0, t), r <= 4 * n, r > 4 * n);
  endtask

  task automatic push_kick(input int cycles);
    for (int k = 0; k < cycles; k++) push_exp(4'd15, 1'b1, 1'b0);
  endtask

  task automatic run_check(input int n);
    exp_t       e;
    logic [3:0] pc;
    logic       exp_pwm;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty edge %0d: got no expectation, expected one queued", ecnt);
      end else begin
        e       = exp_q.pop_front();
        pc      = 4'(ecnt);
        exp_pwm = (pc < e.speed);
        tests += 4;
        if (speed_o !== e.speed) begin
          fails++;
          $display("FAIL speed edge %0d: got %0d expected %0d", ecnt, speed_o, e.speed);
        end
        if (busy_o !== e.busy) begin
          fails++;
          $display("FAIL busy edge %0d: got %b expected %b", ecnt, busy_o, e.busy);
        end
        if (at_target_o !== e.at) begin
          fails++;
          $display("FAIL at_target edge %0d: got %b expected %b", ecnt, at_target_o, e.at);
        end
        if (pwm_o !== exp_pwm) begin
          fails++;
          $display("FAIL pwm edge %0d: got %b expected %b", ecnt, pwm_o, exp_pwm);
        end
      end
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    target = 4'd0;
    #3;
    tests += 4;
    if (speed_o !== 4'd0) begin fails++; $display("FAIL reset_speed: got %0d expected 0", speed_o); end
    if (pwm_o !== 1'b0) begin fails++; $display("FAIL reset_pwm: got %b expected 0", pwm_o); end
    if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    if (at_target_o !== 1'b1) begin fails++; $display("FAIL reset_at_eff0: got %b expected 1", at_target_o); end
    enable = 1'b1;
    target = 4'd6;
    #1;
    tests++;
    if (at_target_o !== 1'b0) begin fails++; $display("FAIL reset_at_eff6: got %b expected 0", at_target_o); end
    tick();
    tick();
    tests++;
    if (speed_o !== 4'd0) begin fails++; $display("FAIL reset_held_speed: got %0d expected 0", speed_o); end
  endtask

  task automatic test_spinup();
    rstn = 1'b1;
    ecnt = 0;
    push_kick(8);
    push_ramp(15, 6, 0, 40);
    run_check(49);
  endtask

  task automatic test_pwm_duty();
    int         highs;
    logic [3:0] pc;
    logic       exp_pwm;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      pc      = 4'(ecnt);
      exp_pwm = (pc < 4'd6);
      tests++;
      if (pwm_o !== exp_pwm) begin
        fails++;
        $display("FAIL pwm6_phase cnt %0d: got %b expected %b", pc, pwm_o, exp_pwm);
      end
      if (pwm_o === 1'b1) highs++;
    end
    tests++;
    if (highs != 6) begin fails++; $display("FAIL pwm6_duty: got %0d highs expected 6", highs); end
  endtask

  task automatic test_ramp_up();
    target = 4'd9;
    push_ramp(6, 9, 0, 16);
    run_check(17);
  endtask

  task automatic test_ramp_to_idle();
    enable = 1'b0;
    push_ramp(9, 0, 0, 40);
    run_check(41);
  endtask

  task automatic test_pwm_zero();
    int highs;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (pwm_o !== 1'b0) highs++;
    end
    tests += 2;
    if (highs != 0) begin fails++; $display("FAIL pwm0_duty: got %0d highs expected 0", highs); end
    if (speed_o !== 4'd0) begin fails++; $display("FAIL idle_speed: got %0d expected 0", speed_o); end
  endtask

  task automatic test_kick_abort();
    enable = 1'b1;
    target = 4'd6;
    push_kick(3);
    run_check(3);
    enable = 1'b0;
    push_ramp(15, 0, 0, 64);
    run_check(65);
  endtask

  task automatic test_retarget();
    enable = 1'b1;
    target = 4'd6;
    push_kick(8);
    push_ramp(15, 6, 0, 21);
    run_check(30);
    target = 4'd12;
    push_ramp(10, 12, 2, 13);
    run_check(12);
  endtask

  task automatic test_reset_mid_ramp();
    target = 4'd4;
    push_ramp(12, 4, 0, 13);
    run_check(14);
    #3;
    rstn = 1'b0;
    #1;
    tests += 4;
    if (speed_o !== 4'd0) begin fails++; $display("FAIL midreset_speed: got %0d expected 0", speed_o); end
    if (pwm_o !== 1'b0) begin fails++; $display("FAIL midreset_pwm: got %b expected 0", pwm_o); end
    if (busy_o !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy_o); end
    if (at_target_o !== 1'b0) begin fails++; $display("FAIL midreset_at: got %b expected 0", at_target_o); end
    tick();
    rstn = 1'b1;
    ecnt = 0;
    push_kick(8);
    push_ramp(15, 4, 0, 48);
    run_check(57);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    ecnt   = 0;
    rstn   = 1'b0;
    enable = 1'b0;
    target = 4'd0;
    test_reset();
    test_spinup();
    test_pwm_duty();
    test_ramp_up();
    test_ramp_to_idle();
    test_pwm_zero();
    test_kick_abort();
    test_retarget();
    test_reset_mid_ramp();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
